// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state enum, width helpers and parameter limits for fifo_wr_arbiter.
package fifo_arb_pkg;
    typedef enum logic {IDLE, GRANT} state_e;
    localparam int NUM_REQ_MIN = 2;
    localparam int NUM_REQ_MAX = 8;
    localparam int MAX_BURST_MIN = 1;
    localparam int MAX_BURST_MAX = 16;
    function automatic int idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    function automatic int cntw(input int mb);
        return $clog2(mb + 1);
    endfunction
endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first request searching upward from last_i+1 with wrap.
module rr_pick import fifo_arb_pkg::*; #(
    parameter int N = 4,
    parameter int W = idw(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] last_i,
    output logic         any_o,
    output logic [W-1:0] idx_o
);
    logic [W-1:0] j;
    assign any_o = |req_i;
    // Scanning from the farthest candidate down lets the nearest one win.
    always_comb begin
        idx_o = last_i;
        j = '0;
        for (int k = N; k >= 1; k--) begin
            j = W'((int'(last_i) + k) % N);
            if (req_i[j]) idx_o = j;
        end
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter for the FIFO write port; FIFO_ARB_TAG_EN prepends gnt_id to wdata.
module fifo_wr_arbiter import fifo_arb_pkg::*; #(
    parameter int NUM_REQ = 4,
    parameter int datawidth = 8,
    parameter int MAX_BURST = 4,
    parameter int IDW = idw(NUM_REQ)
) (
    input  logic                           wclk,
    input  logic                           wrst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_last,
    input  logic [NUM_REQ*datawidth-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           wfull,
`ifdef FIFO_ARB_TAG_EN
    output logic [datawidth+IDW-1:0]       wdata,
`else
    output logic [datawidth-1:0]           wdata,
`endif
    output logic                           winc,
    output logic [IDW-1:0]                 gnt_id,
    output logic                           busy
);
    localparam int CW = cntw(MAX_BURST);
    state_e           state_q;
    logic [IDW-1:0]   gnt_q, last_q, pick;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             any, gv, done;
    logic [datawidth-1:0] data;

    rr_pick #(.N(NUM_REQ), .W(IDW)) u_pick (
        .req_i (req_valid),
        .last_i(last_q),
        .any_o (any),
        .idx_o (pick)
    );

    assign busy      = state_q == GRANT;
    assign gv        = req_valid[gnt_q];
    assign winc      = busy & gv & !wfull;
    assign req_ready = (busy & !wfull) ? NUM_REQ'(1) << gnt_q : '0;
    assign cnt_d     = cnt_q + CW'(1);
    assign done      = req_last[gnt_q] | (cnt_q == CW'(MAX_BURST - 1));
    assign data      = req_data[gnt_q*datawidth +: datawidth];
    assign gnt_id    = gnt_q;
`ifdef FIFO_ARB_TAG_EN
    assign wdata     = {gnt_q, data};
`else
    assign wdata     = data;
`endif

    // A full FIFO stalls in place; only a dropped valid releases without a beat.
    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gnt_q   <= '0;
            last_q  <= IDW'(NUM_REQ - 1);
        end else if (state_q == IDLE) begin
            if (any) begin
                state_q <= GRANT;
                gnt_q   <= pick;
                last_q  <= pick;
                cnt_q   <= '0;
            end
        end else if (!gv) begin
            state_q <= IDLE;
        end else if (!wfull) begin
            state_q <= done ? IDLE : GRANT;
            cnt_q   <= done ? '0 : cnt_d;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: table-driven and directed checks of fifo_wr_arbiter with NUM_REQ=4, MAX_BURST=4.
module tb_fifo_wr_arbiter;
`ifdef FIFO_ARB_TAG_EN
    localparam int WW = 10;
`else
    localparam int WW = 8;
`endif
    typedef struct {
        logic       rst_n;
        logic [3:0] v, l;
        logic       f;
        logic       w;
        logic [3:0] r;
        logic       b;
        logic [1:0] g;
        logic [7:0] d;
    } vec_t;

    logic          wclk = 0;
    logic          wrst_n;
    logic [3:0]    req_valid, req_last, req_ready;
    logic [31:0]   req_data;
    logic          wfull, winc, busy;
    logic [WW-1:0] wdata;
    logic [1:0]    gnt_id;
    int            cmp = 0, err = 0;
    vec_t          tbl[22];

    fifo_wr_arbiter #(.NUM_REQ(4), .datawidth(8), .MAX_BURST(4)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .req_valid(req_valid), .req_last(req_last),
        .req_data(req_data), .req_ready(req_ready), .wfull(wfull), .wdata(wdata),
        .winc(winc), .gnt_id(gnt_id), .busy(busy)
    );

    always #5 wclk = ~wclk;

    function automatic vec_t mk(logic rst_n, logic [3:0] v, logic [3:0] l, logic f,
                                logic w, logic [3:0] r, logic b, logic [1:0] g, logic [7:0] d);
        vec_t x;
        x.rst_n = rst_n; x.v = v; x.l = l; x.f = f;
        x.w = w; x.r = r; x.b = b; x.g = g; x.d = d;
        return x;
    endfunction

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        cmp++;
        if (a !== e) begin
            err++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic chk_out(input string n, input logic w, input logic [3:0] r, input logic b,
                           input logic [1:0] g, input logic [7:0] d);
        chk({n, ".winc"}, 32'(winc), 32'(w));
        chk({n, ".ready"}, 32'(req_ready), 32'(r));
        chk({n, ".busy"}, 32'(busy), 32'(b));
        chk({n, ".gnt"}, 32'(gnt_id), 32'(g));
        chk({n, ".wdata"}, 32'(wdata[7:0]), 32'(d));
`ifdef FIFO_ARB_TAG_EN
        chk({n, ".tag"}, 32'(wdata[9:8]), 32'(gnt_id));
`endif
    endtask

    task automatic cyc();
        @(posedge wclk);
        #1;
    endtask

    initial begin
        tbl[0]  = mk(0, 4'h6, 0, 0, 0, 4'h0, 0, 0, 8'h11);
        tbl[1]  = mk(1, 4'h6, 0, 0, 0, 4'h0, 0, 0, 8'h11);
        for (int i = 2; i <= 5; i++) tbl[i] = mk(1, 4'h6, 0, 0, 1, 4'h2, 1, 1, 8'h22);
        tbl[6]  = mk(1, 4'h6, 0, 0, 0, 4'h0, 0, 1, 8'h22);
        tbl[7]  = mk(1, 4'h6, 0, 0, 1, 4'h4, 1, 2, 8'h33);
        tbl[8]  = mk(1, 4'h6, 0, 0, 1, 4'h4, 1, 2, 8'h33);
        for (int i = 9; i <= 11; i++) tbl[i] = mk(1, 4'h6, 0, 1, 0, 4'h0, 1, 2, 8'h33);
        tbl[12] = mk(1, 4'h6, 0, 0, 1, 4'h4, 1, 2, 8'h33);
        tbl[13] = mk(1, 4'h6, 0, 0, 1, 4'h4, 1, 2, 8'h33);
        tbl[14] = mk(1, 4'h6, 0, 0, 0, 4'h0, 0, 2, 8'h33);
        tbl[15] = mk(1, 4'h6, 0, 0, 1, 4'h2, 1, 1, 8'h22);
        tbl[16] = mk(1, 4'h4, 0, 0, 0, 4'h2, 1, 1, 8'h22);
        tbl[17] = mk(1, 4'h4, 0, 0, 0, 4'h0, 0, 1, 8'h22);
        tbl[18] = mk(1, 4'h4, 0, 0, 1, 4'h4, 1, 2, 8'h33);
        tbl[19] = mk(1, 4'h4, 4'h4, 0, 1, 4'h4, 1, 2, 8'h33);
        tbl[20] = mk(1, 4'h0, 0, 0, 0, 4'h0, 0, 2, 8'h33);
        tbl[21] = mk(1, 4'h0, 0, 1, 0, 4'h0, 0, 2, 8'h33);

        wrst_n = 0; req_valid = 0; req_last = 0; wfull = 0; req_data = 32'h44332211;
        repeat (2) @(posedge wclk);
        #1;
        for (int i = 0; i < 22; i++) begin
            wrst_n = tbl[i].rst_n; req_valid = tbl[i].v; req_last = tbl[i].l; wfull = tbl[i].f;
            @(negedge wclk);
            chk_out($sformatf("vec%0d", i), tbl[i].w, tbl[i].r, tbl[i].b, tbl[i].g, tbl[i].d);
            cyc();
        end

        req_valid = 4'hF; req_last = 0; wfull = 0;
        @(negedge wclk);
        chk_out("rst.idle", 0, 4'h0, 0, 2, 8'h33);
        cyc();
        @(negedge wclk);
        chk_out("rst.beat1", 1, 4'h8, 1, 3, 8'h44);
        cyc();
        wrst_n = 0;
        @(negedge wclk);
        chk_out("rst.beat2", 1, 4'h8, 1, 3, 8'h44);
        cyc();
        @(negedge wclk);
        chk_out("rst.after", 0, 4'h0, 0, 0, 8'h11);
        wrst_n = 1;
        cyc();
        for (int k = 0; k < 5; k++) begin
            for (int b = 0; b < 4; b++) begin
                @(negedge wclk);
                chk_out($sformatf("rr%0d.b%0d", k, b), 1, 4'(1 << (k % 4)), 1, 2'(k % 4),
                        8'(8'h11 * (k % 4 + 1)));
                cyc();
            end
            @(negedge wclk);
            chk_out($sformatf("rr%0d.gap", k), 0, 4'h0, 0, 2'(k % 4), 8'(8'h11 * (k % 4 + 1)));
            if (k == 4) req_valid = 0;
            cyc();
        end

        req_valid = 4'h4; req_data[23:16] = 8'hA1;
        @(negedge wclk);
        chk_out("pkt.idle", 0, 4'h0, 0, 0, 8'h11);
        cyc();
        @(negedge wclk);
        chk_out("pkt.A1", 1, 4'h4, 1, 2, 8'hA1);
        cyc();
        req_data[23:16] = 8'hA2; req_last = 4'h4;
        @(negedge wclk);
        chk_out("pkt.A2", 1, 4'h4, 1, 2, 8'hA2);
        cyc();
        req_valid = 0; req_last = 0;
        @(negedge wclk);
        chk_out("pkt.end", 0, 4'h0, 0, 2, 8'hA2);
        cyc();
        @(negedge wclk);
        chk_out("pkt.end2", 0, 4'h0, 0, 2, 8'hA2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end
endmodule
